// File: rtl/seg7_mux_driver.sv
// Multiplexed hex display driver: double-buffered value, one lit digit per slot, blanking between slots.
// Optional leading-zero blanking is enabled by defining SEG7_MUX_LZ_BLANK_EN.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int P_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [P_W-1:0]        P_LAST   = P_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // XOR masks: applying them to an active-high pattern yields the pin polarity.
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [P_W-1:0]          p_q, p_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    lz_blank;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

`ifdef SEG7_MUX_LZ_BLANK_EN
    // zero_above[i] is set when nibble i and every higher nibble of the display are zero.
    logic [NUM_DIGITS:0] zero_above;
    assign zero_above[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign zero_above[gi] = zero_above[gi+1] & (disp_val_q[4*gi +: 4] == 4'h0);
    end
    assign lz_blank = (idx_q != '0) && zero_above[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        p_d          = p_q + P_W'(1);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp;
            pending_d    = 1'b1;
        end

        if (p_q == P_LAST) begin
            p_d   = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
                frame_done_d = 1'b1;
                pending_d    = 1'b0;
                // A load landing on the boundary goes straight to the display.
                if (load) begin
                    disp_val_d = value;
                    disp_dp_d  = dp;
                end else if (pending_q) begin
                    disp_val_d = shadow_val_q;
                    disp_dp_d  = shadow_dp_q;
                end
            end
        end

        seg_d    = SEG_OFF;
        dp_out_d = DP_OFF;
        dig_d    = DIG_OFF;
        if (p_q != '0) begin
            seg_d    = (lz_blank ? 7'h00 : glyph(disp_val_q[{idx_q, 2'b00} +: 4])) ^ SEG_OFF;
            dp_out_d = disp_dp_q[idx_q] ^ DP_OFF;
            dig_d    = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q          <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            dig_q        <= DIG_OFF;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            dig_q        <= dig_d;
        end
    end

    assign segments   = seg_q;
    assign dp_out     = dp_out_q;
    assign digit_sel  = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: an active-high instance and an active-low instance on a shared clock.
`timescale 1ns/1ps
module tb_seg7_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value, value_n;
    logic [3:0]  dp, dp_n;
    logic        load, load_n;
    logic [6:0]  segments, segments_n;
    logic        dp_out, dp_out_n;
    logic [3:0]  digit_sel, digit_sel_n;
    logic        frame_done, frame_done_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
        .segments(segments), .dp_out(dp_out), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    seg7_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .value(value_n), .dp(dp_n), .load(load_n),
        .segments(segments_n), .dp_out(dp_out_n), .digit_sel(digit_sel_n), .frame_done(frame_done_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs to the next frame_done pulse; optionally checks every lit digit shows old_seg.
    task automatic wait_frame(input bit check_old, input logic [6:0] old_seg);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (check_old && digit_sel != 4'b0000) chk("old_display", {25'd0, segments}, {25'd0, old_seg});
            seen = (frame_done === 1'b1);
        end
        if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    // Checks one full frame, starting just after a frame_done pulse. e = {d3,d2,d1,d0}.
    task automatic check_frame(input string name, input logic [27:0] e, input logic [3:0] edp);
        int nerr = errors;
        for (int t = 0; t < 16; t++) begin
            int d = t / 4;
            bit lit = (t % 4) != 0;
            logic [3:0] sel = lit ? (4'b0001 << d) : 4'b0000;
            logic [6:0] sg  = lit ? e[d*7 +: 7] : 7'h00;
            logic       pt  = lit ? edp[d] : 1'b0;
            tick();
            chk({name, "_sel"}, {28'd0, digit_sel}, {28'd0, sel});
            chk({name, "_seg"}, {25'd0, segments}, {25'd0, sg});
            chk({name, "_dp"}, {31'd0, dp_out}, {31'd0, pt});
            chk({name, "_fd"}, {31'd0, frame_done}, {31'd0, t == 15});
            chk({name, "_n_sel"}, {28'd0, digit_sel_n}, {28'd0, ~sel});
            chk({name, "_n_seg"}, {25'd0, segments_n}, lit ? 32'h00 : 32'h7F);
            chk({name, "_n_dp"}, {31'd0, dp_out_n}, 32'd1);
        end
        $display("frame %s: errors so far %0d (new %0d)", name, errors, errors - nerr);
    endtask

    initial begin
        rst_n = 1'b0;
        value = '0; dp = '0; load = 1'b0;
        value_n = '0; dp_n = '0; load_n = 1'b0;

        #12;
        chk("rst_sel", {28'd0, digit_sel}, 32'h0);
        chk("rst_seg", {25'd0, segments}, 32'h00);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_n_sel", {28'd0, digit_sel_n}, 32'hF);
        chk("rst_n_seg", {25'd0, segments_n}, 32'h7F);
        $display("reset: checked idle outputs");
        #10 rst_n = 1'b1;

        tick();
        chk("first_blank_sel", {28'd0, digit_sel}, 32'h0);
        tick();
        chk("first_lit_sel", {28'd0, digit_sel}, 32'h1);
        chk("first_lit_seg", {25'd0, segments}, 32'h3F);
        chk("first_lit_n_sel", {28'd0, digit_sel_n}, 32'hE);
        chk("first_lit_n_seg", {25'd0, segments_n}, 32'h40);
        $display("release: first lit digit checked");

        // Load at cycle 2 of a frame: old zeros remain until the boundary.
        wait_frame(1'b1, 7'h3F);
        tick(); tick();
        value = 16'h12AF; dp = 4'b0100; load = 1'b1;
        value_n = 16'h8888; dp_n = 4'b0000; load_n = 1'b1;
        tick();
        load = 1'b0; load_n = 1'b0;
        wait_frame(1'b1, 7'h3F);
        check_frame("load_12AF", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100);

        // Two loads in one frame: the last one wins.
        tick(); tick();
        value = 16'h1111; dp = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        value = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        wait_frame(1'b0, 7'h00);
        check_frame("last_wins_2222", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

        // Load exactly on the frame-boundary cycle bypasses the shadow.
        for (int i = 0; i < 15; i++) tick();
        value = 16'h00C3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("bnd_fd", {31'd0, frame_done}, 32'd1);
        chk("bnd_pending", {31'd0, dut.pending_q}, 32'd0);
`ifdef SEG7_MUX_LZ_BLANK_EN
        check_frame("bnd_00C3", {7'h00, 7'h00, 7'h39, 7'h4F}, 4'b0000);
`else
        check_frame("bnd_00C3", {7'h3F, 7'h3F, 7'h39, 7'h4F}, 4'b0000);
`endif
        chk("bnd_pending_after", {31'd0, dut.pending_q}, 32'd0);

        // Leading-zero cases.
        tick();
        value = 16'h0050; load = 1'b1;
        tick();
        load = 1'b0;
        wait_frame(1'b0, 7'h00);
`ifdef SEG7_MUX_LZ_BLANK_EN
        check_frame("lz_0050", {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
`else
        check_frame("lz_0050", {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000);
`endif
        tick();
        value = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        wait_frame(1'b0, 7'h00);
`ifdef SEG7_MUX_LZ_BLANK_EN
        check_frame("lz_0000", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
`else
        check_frame("lz_0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
